// File: rtl/seg_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_disp_pkg
// Description : Shared types and constants for the 8-digit display scheduler:
//               arbiter state encoding, display geometry, parameter defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_disp_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int DIGIT_W    = 4;
  localparam int IDX_W      = 3;

  localparam int SCAN_DIV_DEFAULT     = 50000;
  localparam int MIN_FRAMES_DEFAULT   = 4;
  localparam int BLINK_FRAMES_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seg_scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_timer
// Description : Digit-slot divider and scan index for the multiplexed display.
//               Produces the one-hot digit enable, a combinational frame
//               boundary strobe (last tick of digit 7) and a registered
//               frame_start pulse in the first cycle of digit 0.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_timer
  import seg_disp_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [IDX_W-1:0]      scan_idx,
  output logic [NUM_DIGITS-1:0] seg_en,
  output logic                  frame_bound,
  output logic                  frame_start
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] r_div;
  logic [IDX_W-1:0] r_idx;
  logic             r_frame_start;
  logic             w_tick;

  assign w_tick      = (r_div == c_div_last);
  assign frame_bound = w_tick && (r_idx == c_idx_last);
  assign scan_idx    = r_idx;
  assign seg_en      = NUM_DIGITS'(1) << r_idx;
  assign frame_start = r_frame_start;

  // Clock divider: one tick every SCAN_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + DIV_W'(1);
  end

  // Scan index advances per tick; 3-bit width wraps 7 -> 0 naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_idx <= '0;
    else if (w_tick) r_idx <= r_idx + IDX_W'(1);
  end

  // frame_start marks the first cycle of digit 0 after a boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_start <= 1'b0;
    else        r_frame_start <= frame_bound;
  end

endmodule
`default_nettype wire

// File: rtl/seg_disp_sched.sv
`default_nettype none
// ============================================================================
// Module      : seg_disp_sched
// Description : Two-port arbiter for an 8-digit multiplexed 7-segment display.
//               Port 1 has priority but may only preempt port 0 after port 0
//               has held the display long enough. Ownership and the displayed
//               data snapshot change only at frame boundaries.
//               Optional feature macro: SEG_DISP_BLINK_EN (per-digit blinking
//               of port 1 digits).
// Revision    : 1.0 - initial release
// ============================================================================
module seg_disp_sched
  import seg_disp_pkg::*;
#(
  parameter int SCAN_DIV     = SCAN_DIV_DEFAULT,
  parameter int MIN_FRAMES   = MIN_FRAMES_DEFAULT,
  parameter int BLINK_FRAMES = BLINK_FRAMES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [31:0] data0,
  input  logic [7:0]  dp0,
  output logic        gnt0,
  input  logic        req1,
  input  logic [31:0] data1,
  input  logic [7:0]  dp1,
  input  logic [7:0]  blink1,
  output logic        gnt1,
  output logic [7:0]  seg_en,
  output logic [3:0]  digit,
  output logic        dp,
  output logic        blank,
  output logic        frame_start
);

  localparam int HOLD_W = $clog2(MIN_FRAMES + 1);
  localparam logic [HOLD_W-1:0] c_hold_max = HOLD_W'(MIN_FRAMES);

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [HOLD_W-1:0]             r_hold;
  logic [NUM_DIGITS*DIGIT_W-1:0] r_snap_data;
  logic [NUM_DIGITS-1:0]         r_snap_dp;
  logic [IDX_W-1:0]              w_idx;
  logic [IDX_W+1:0]              w_nib_lsb;
  logic                          w_bound;

  seg_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_idx    (w_idx),
    .seg_en      (seg_en),
    .frame_bound (w_bound),
    .frame_start (frame_start)
  );

  // Arbiter state register, updated only at frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_state <= IDLE;
    else if (w_bound) r_state <= w_state_nxt;
  end

  // Next-state: port 1 wins ties; port 0 is preempted only once hold saturates.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (req1)      w_state_nxt = GNT1;
        else if (req0) w_state_nxt = GNT0;
      end
      GNT0: begin
        if (!req0)                            w_state_nxt = req1 ? GNT1 : IDLE;
        else if (req1 && r_hold == c_hold_max) w_state_nxt = GNT1;
      end
      GNT1: begin
        if (!req1) w_state_nxt = req0 ? GNT0 : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grants decode directly from the state register, so they are mutually exclusive.
  always_comb begin
    gnt0 = (r_state == GNT0);
    gnt1 = (r_state == GNT1);
  end

  // Hold counter: frames spent in the current state, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (w_bound) begin
      if (w_state_nxt != r_state)  r_hold <= '0;
      else if (r_hold != c_hold_max) r_hold <= r_hold + HOLD_W'(1);
    end
  end

  // Snapshot of the owning port's digits, frozen for the whole next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_data <= '0;
      r_snap_dp   <= '0;
    end else if (w_bound) begin
      case (w_state_nxt)
        GNT0: begin
          r_snap_data <= data0;
          r_snap_dp   <= dp0;
        end
        GNT1: begin
          r_snap_data <= data1;
          r_snap_dp   <= dp1;
        end
        default: begin
          r_snap_data <= '0;
          r_snap_dp   <= '0;
        end
      endcase
    end
  end

  assign w_nib_lsb = {w_idx, 2'b00};
  assign digit     = r_snap_data[w_nib_lsb +: DIGIT_W];
  assign dp        = r_snap_dp[w_idx];

`ifdef SEG_DISP_BLINK_EN
  localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BC_W-1:0] c_blink_last = BC_W'(BLINK_FRAMES - 1);

  logic [BC_W-1:0]       r_blink_cnt;
  logic                  r_blink_on;
  logic [NUM_DIGITS-1:0] r_snap_blink;

  // Frame counter toggling the blink phase; phase starts "on" after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_bound) begin
      if (r_blink_cnt == c_blink_last) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + BC_W'(1);
      end
    end
  end

  // Blink mask is captured alongside the port 1 snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_snap_blink <= '0;
    else if (w_bound) r_snap_blink <= (w_state_nxt == GNT1) ? blink1 : '0;
  end

  // Dark when idle, or for masked port 1 digits during the off phase.
  always_comb begin
    blank = (r_state == IDLE);
    if ((r_state == GNT1) && !r_blink_on && r_snap_blink[w_idx]) blank = 1'b1;
  end
`else
  logic w_unused_blink;
  assign w_unused_blink = ^{blink1, BLINK_FRAMES[0]};

  // Dark only while no port owns the display.
  always_comb begin
    blank = (r_state == IDLE);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_disp_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_disp_sched
// Description : Self-checking bench for seg_disp_sched with SCAN_DIV=4,
//               MIN_FRAMES=2, BLINK_FRAMES=2 (32-cycle frames). Table-driven
//               arbitration/display vectors plus hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_disp_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] data0 = '0, data1 = '0;
  logic [7:0]  dp0 = '0, dp1 = '0, blink1 = '0;
  logic        gnt0, gnt1, dp, blank, frame_start;
  logic [7:0]  seg_en;
  logic [3:0]  digit;

  int n_checks = 0;
  int n_err    = 0;

  seg_disp_sched #(
    .SCAN_DIV     (4),
    .MIN_FRAMES   (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0        (req0),
    .data0       (data0),
    .dp0         (dp0),
    .gnt0        (gnt0),
    .req1        (req1),
    .data1       (data1),
    .dp1         (dp1),
    .blink1      (blink1),
    .gnt1        (gnt1),
    .seg_en      (seg_en),
    .digit       (digit),
    .dp          (dp),
    .blank       (blank),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r0;
    logic        r1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [7:0]  p0;
    logic [7:0]  p1;
    logic        eg0;
    logic        eg1;
    logic        eblank;
    logic [31:0] eword;
    logic [7:0]  edp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance to the next frame_start pulse (sampled at negedge); bounded.
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 64);
    if (frame_start !== 1'b1) begin
      n_checks++;
      n_err++;
      $display("FAIL frame_start_timeout: actual=none required=pulse within 64 cycles");
    end
  endtask

  // Check all 8 slots of the frame that just started.
  task automatic check_frame(input string tag, input logic eblank,
                             input logic [31:0] eword, input logic [7:0] edp);
    logic [7:0] exp_en;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      exp_en = 8'd1 << i;
      chk({tag, "_seg_en"}, seg_en, exp_en);
      chk({tag, "_blank"}, blank, eblank);
      if (!eblank) begin
        chk({tag, "_digit"}, digit, (eword >> (4 * i)) & 32'hF);
        chk({tag, "_dp"}, dp, edp[i]);
      end
      if (i < 7) repeat (4) @(negedge clk);
    end
  endtask

  function automatic logic blink_off(input int k);
`ifdef SEG_DISP_BLINK_EN
    return ((k / 2) % 2) == 1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg_en"}, seg_en, 8'h01);
    chk({tag, "_digit"}, digit, 4'h0);
    chk({tag, "_dp"}, dp, 1'b0);
    chk({tag, "_blank"}, blank, 1'b1);
    chk({tag, "_gnt0"}, gnt0, 1'b0);
    chk({tag, "_gnt1"}, gnt1, 1'b0);
    chk({tag, "_frame_start"}, frame_start, 1'b0);
  endtask

  initial begin
    int n;

    //         r0    r1    d0            d1            p0     p1     g0    g1    blank word          dp
    vecs[0] = '{1'b0, 1'b0, 32'h0,        32'h0,        8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0,        8'h00};
    vecs[1] = '{1'b1, 1'b0, 32'h76543210, 32'h0,        8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 32'h76543210, 8'h05};
    vecs[2] = '{1'b1, 1'b0, 32'h89ABCDEF, 32'h0,        8'hF0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h89ABCDEF, 8'hF0};
    vecs[3] = '{1'b0, 1'b1, 32'h0,        32'h13579BDF, 8'h00, 8'hA0, 1'b0, 1'b1, 1'b0, 32'h13579BDF, 8'hA0};
    vecs[4] = '{1'b1, 1'b1, 32'h11111111, 32'h2468ACE0, 8'hFF, 8'h3C, 1'b0, 1'b1, 1'b0, 32'h2468ACE0, 8'h3C};
    vecs[5] = '{1'b1, 1'b1, 32'h11111111, 32'h2468ACE0, 8'hFF, 8'h3C, 1'b0, 1'b1, 1'b0, 32'h2468ACE0, 8'h3C};
    vecs[6] = '{1'b1, 1'b0, 32'hFEDCBA98, 32'h0,        8'h81, 8'h00, 1'b1, 1'b0, 1'b0, 32'hFEDCBA98, 8'h81};
    vecs[7] = '{1'b0, 1'b0, 32'h0,        32'h0,        8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0,        8'h00};
    vecs[8] = '{1'b1, 1'b1, 32'h99999999, 32'h0F0F0F0F, 8'h00, 8'h55, 1'b0, 1'b1, 1'b0, 32'h0F0F0F0F, 8'h55};
    vecs[9] = '{1'b0, 1'b0, 32'h0,        32'h0,        8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 32'h0,        8'h00};

    // Power-on reset values, sampled away from any clock edge.
    #23;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // First boundary 8*SCAN_DIV cycles after release, then a 32-cycle period.
    wait_fs(n);
    chk("first_frame_latency", n, 32);
    @(negedge clk);
    chk("frame_start_one_cycle", frame_start, 1'b0);
    wait_fs(n);
    chk("frame_period", n, 31);

    // Table-driven arbitration and display vectors.
    for (int v = 0; v < 10; v++) begin
      req0  = vecs[v].r0;
      req1  = vecs[v].r1;
      data0 = vecs[v].d0;
      data1 = vecs[v].d1;
      dp0   = vecs[v].p0;
      dp1   = vecs[v].p1;
      wait_fs(n);
      chk($sformatf("vec%0d_gnt0", v), gnt0, vecs[v].eg0);
      chk($sformatf("vec%0d_gnt1", v), gnt1, vecs[v].eg1);
      check_frame($sformatf("vec%0d", v), vecs[v].eblank, vecs[v].eword, vecs[v].edp);
    end

    // Preemption of port 0 waits for the hold counter to reach MIN_FRAMES.
    req0 = 1'b1; data0 = 32'h76543210; dp0 = 8'h00;
    wait_fs(n);
    chk("pre_f0_gnt0", gnt0, 1'b1);
    wait_fs(n);
    chk("pre_f1_gnt0", gnt0, 1'b1);
    req1 = 1'b1; data1 = 32'hCAFEF00D; dp1 = 8'h00;
    wait_fs(n);
    chk("pre_f2_gnt0_held", gnt0, 1'b1);
    chk("pre_f2_gnt1_held", gnt1, 1'b0);
    wait_fs(n);
    chk("pre_f3_gnt0", gnt0, 1'b0);
    chk("pre_f3_gnt1", gnt1, 1'b1);
    check_frame("pre_f3", 1'b0, 32'hCAFEF00D, 8'h00);

    // Port 1 is never preempted; dropping req1 hands back to port 0.
    wait_fs(n);
    chk("nopre_a_gnt1", gnt1, 1'b1);
    wait_fs(n);
    chk("nopre_b_gnt1", gnt1, 1'b1);
    req1 = 1'b0;
    wait_fs(n);
    chk("handback_gnt0", gnt0, 1'b1);
    chk("handback_gnt1", gnt1, 1'b0);

    // Mid-frame data change must not disturb the current frame.
    wait_fs(n);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        data0 = 32'hFFFFFFFF;
        dp0   = 8'hFF;
      end
      chk($sformatf("midframe_digit%0d", i), digit, i);
      if (i < 7) repeat (4) @(negedge clk);
    end
    wait_fs(n);
    @(negedge clk);
    chk("newframe_digit", digit, 4'hF);
    chk("newframe_dp", dp, 1'b1);

    // Asynchronous reset at digit 5 mid-frame.
    repeat (20) @(negedge clk);
    chk("pre_rst_seg_en", seg_en, 8'h20);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");

    // Release into a port 1 request with digit 0 blinking.
    req0 = 1'b0; req1 = 1'b1; data1 = 32'h55555555; dp1 = 8'h00; blink1 = 8'h01;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs(n);
    chk("rst_first_frame_latency", n, 32);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) wait_fs(n);
      chk($sformatf("blink_f%0d_gnt1", k), gnt1, 1'b1);
      @(negedge clk);
      chk($sformatf("blink_f%0d_d0_blank", k), blank, blink_off(k));
      repeat (4) @(negedge clk);
      chk($sformatf("blink_f%0d_d1_blank", k), blank, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
